// File: rtl/data_mem_sized_pkg.sv
// Shared constants for the MEM-stage data memory: enable/write codes, access sizes
// and the alignment rule.
package data_mem_sized_pkg;

  localparam logic        RamEnable = 1'b1;
  localparam logic        RamWrite  = 1'b1;
  localparam logic [31:0] Zero      = 32'h0000_0000;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  // Reserved size 2'b11 is never aligned.
  function automatic logic size_aligned(input logic [1:0] size, input logic [1:0] offset);
    logic ok;
    case (size)
      SZ_BYTE: ok = 1'b1;
      SZ_HALF: ok = ~offset[0];
      SZ_WORD: ok = (offset == 2'b00);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/data_mem_sized_lane_fmt.sv
// Combinational lane formatter: store-side lane enables and positioned write word,
// load-side lane extraction with sign/zero extension.
module data_mem_sized_lane_fmt
  import data_mem_sized_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  offset,
  input  logic        sign_ext,
  input  logic [31:0] wt_data,
  input  logic [31:0] rd_word,
  output logic [3:0]  lane_en,
  output logic [31:0] wr_word,
  output logic [31:0] ld_data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    lane_en = 4'b0000;
    wr_word = wt_data;
    case (size)
      SZ_BYTE: begin
        lane_en = 4'b0001 << offset;
        wr_word = {4{wt_data[7:0]}};
      end
      SZ_HALF: begin
        lane_en = offset[1] ? 4'b1100 : 4'b0011;
        wr_word = {2{wt_data[15:0]}};
      end
      SZ_WORD: begin
        lane_en = 4'b1111;
        wr_word = wt_data;
      end
      default: begin
        lane_en = 4'b0000;
        wr_word = wt_data;
      end
    endcase
  end

  always_comb begin
    byte_sel = rd_word[{offset, 3'b000} +: 8];
    half_sel = rd_word[{offset[1], 4'b0000} +: 16];
    case (size)
      SZ_BYTE: ld_data = {{24{sign_ext & byte_sel[7]}}, byte_sel};
      SZ_HALF: ld_data = {{16{sign_ext & half_sel[15]}}, half_sel};
      default: ld_data = rd_word;
    endcase
  end

endmodule

// File: rtl/data_mem_sized.sv
// Single-port data memory with byte/half/word access, registered loads and
// one-cycle misalign/range error strobes.
module data_mem_sized
  import data_mem_sized_pkg::*;
#(
  parameter int unsigned DEPTH     = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter bit          INIT_ZERO = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce,
  input  logic        we,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [31:0] addr,
  input  logic [31:0] wt_data,
  output logic [31:0] rd_data,
  output logic        rd_valid,
  output logic        misalign,
  output logic        range_err
);

  localparam int unsigned AW   = $clog2(DEPTH);
  localparam logic [31:0] Span = 32'(DEPTH * 4);

  // Initial value only matters in simulation; contents are never reset.
  logic [31:0] mem_q [DEPTH] = '{default: (INIT_ZERO ? Zero : {32{1'bx}})};

  logic [31:0]   rel_addr;
  logic [AW-1:0] idx;
  logic          in_range, aligned, is_store, is_load;
  logic [3:0]    lane_en;
  logic [31:0]   wr_word, rd_word, ld_data;
  logic [31:0]   rd_data_d, rd_data_q;
  logic          rd_valid_q, misalign_q, range_err_q;

  always_comb begin
    rel_addr = addr - BASE_ADDR;
    idx      = rel_addr[AW+1:2];
    in_range = (rel_addr < Span);
    aligned  = size_aligned(size, addr[1:0]);
    is_store = (ce == RamEnable) && aligned && in_range && (we == RamWrite);
    is_load  = (ce == RamEnable) && aligned && in_range && (we != RamWrite);
    rd_word  = mem_q[idx];
  end

  data_mem_sized_lane_fmt u_lane_fmt (
    .size     (size),
    .offset   (addr[1:0]),
    .sign_ext (sign_ext),
    .wt_data  (wt_data),
    .rd_word  (rd_word),
    .lane_en  (lane_en),
    .wr_word  (wr_word),
    .ld_data  (ld_data)
  );

  always_ff @(posedge clk) begin
    if (is_store) begin
      for (int b = 0; b < 4; b++) begin
        if (lane_en[b]) mem_q[idx][8*b +: 8] <= wr_word[8*b +: 8];
      end
    end
  end

  always_comb begin
    rd_data_d = is_load ? ld_data : rd_data_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_data_q   <= Zero;
      rd_valid_q  <= 1'b0;
      misalign_q  <= 1'b0;
      range_err_q <= 1'b0;
    end else begin
      rd_data_q   <= rd_data_d;
      rd_valid_q  <= is_load;
      misalign_q  <= (ce == RamEnable) && !aligned;
      range_err_q <= (ce == RamEnable) && !in_range;
    end
  end

  assign rd_data   = rd_data_q;
  assign rd_valid  = rd_valid_q;
  assign misalign  = misalign_q;
  assign range_err = range_err_q;

endmodule

// File: doc/data_mem_sized.md
Name: data_mem_sized

Overview:
- Parametrised single-port data memory for the five-stage pipeline's MEM stage.
- Successor of the word-only data memory: adds byte/halfword/word stores with byte-lane enables and sign/zero-extended sub-word loads.
- Reads are registered with one-cycle latency and a valid strobe.
- Flags misaligned and out-of-range accesses.

Parameters:
- DEPTH, 1024, number of 32-bit words; power of two, at least 2.
- BASE_ADDR, 32'h0000_0000, byte address of word 0; DEPTH*4-aligned.
- INIT_ZERO, 0, 1 = simulation-only zero-fill of the array at time 0.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-low reset.
- ce  in  1  chip enable; RamEnable starts an access this cycle.
- we  in  1  RamWrite = store, otherwise load; ignored when ce is RamDisable.
- size  in  2  access size: SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10; 2'b11 reserved, treated as misaligned.
- sign_ext  in  1  loads only: 1 = sign-extend the sub-word, 0 = zero-extend.
- addr  in  32  byte address.
- wt_data  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- rd_data  out  32  load result, registered.
- rd_valid  out  1  one-cycle pulse; rd_data holds a new load result.
- misalign  out  1  one-cycle pulse: the previous cycle's access was misaligned or had a reserved size.
- range_err  out  1  one-cycle pulse: the previous cycle's access fell outside [BASE_ADDR, BASE_ADDR+4*DEPTH).

Behaviour:
- Reset (rst low, asynchronous): rd_data=`Zero, rd_valid=0, misalign=0, range_err=0. Array contents are not reset and are retained across reset.
- Address decode:
  - Word index = (addr-BASE_ADDR)[log2(DEPTH)+1:2].
  - Lane offset = addr[1:0].
- Alignment rule:
  - Half requires addr[0]=0.
  - Word requires addr[1:0]=0.
  - Byte is always aligned.
  - Reserved size is always misaligned.
- Legal access = ce && aligned && in range. Single port: at most one access per cycle.
- Store (legal, we=1), at the edge:
  - Byte lanes written per offset.
  - Byte: lane=offset, data wt_data[7:0] replicated into that lane.
  - Half: lanes {off+1,off}, data wt_data[15:0].
  - Word: all lanes.
  - Unselected lanes unchanged.
  - rd_valid stays 0.
- Load (legal, we=0):
  - Edge N: array word read, then formatted (lane select, then sign/zero extension to 32) and registered into rd_data.
  - rd_valid=1 during cycle N+1.
  - rd_data holds its value until the next load result or reset.
- Illegal access (ce=1, misaligned or out of range):
  - No array write; rd_data unchanged.
  - misalign and/or range_err = 1 in the following cycle. Both may assert together.
  - rd_valid=0 even if we=0.
- ce=0: no access, no strobes. we, size, addr, wt_data ignored.
- Store followed by load of the same word in the next cycle returns the newly stored data; write-first ordering is inherent, no bypass needed.
- Back-to-back loads: one result per cycle, rd_valid stays high continuously.
- Reset asserted mid-access: the pending result and strobes are dropped. If rst rises with ce=1, that edge performs a normal access.

Decomposition:
- Shared define file additions:
  - SZ_BYTE, SZ_HALF, SZ_WORD size codes.
  - Existing RamEnable/RamDisable/RamWrite/Zero constants reused.
- Natural sub-module: mem_lane_fmt, combinational.
  - Store side: produces the 4-bit lane-enable and the lane-positioned write word from size/offset/wt_data.
  - Load side: extracts and extends the read word from size/offset/sign_ext.
- The top module holds the array, access check and output registers.

Test Plan:
- Reset: drive rst low with arbitrary inputs -> rd_data=0, rd_valid=0, misalign=0, range_err=0.
- Word store/load: SW 32'hDEADBEEF at 0x10, then LW 0x10 -> next cycle rd_valid=1, rd_data=32'hDEADBEEF.
- Byte/half lanes: SW 0 at 0x20, SB 8'h80 at 0x22, SH 16'h8001 at 0x20:
  - LW 0x20 -> 32'h0080_8001.
  - LB 0x22 sign -> 32'hFFFF_FF80.
  - LBU 0x22 -> 32'h0000_0080.
  - LH 0x20 sign -> 32'hFFFF_8001.
- Misalignment: SW 32'h1234_5678 at 0x32 -> misalign=1 next cycle. Word at 0x30 unchanged (verify by a prior known value). LH at 0x21 -> misalign=1, rd_valid=0.
- Range: LW at BASE_ADDR+4*DEPTH -> range_err=1, rd_valid=0, rd_data retains its previous value.
- Back-to-back loads with reset mid-stream:
  - LW 0x10, LW 0x20, LW 0x30 on consecutive cycles -> rd_valid high for 3 cycles with the matching data.
  - Repeat with rst low on the second cycle -> strobes clear immediately, rd_data=0, memory contents intact on a later LW.
